// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline-stage register placed between two pipeline stages.
// A packed stage struct travels through the block as an opaque WIDTH-bit
// payload held in a DEPTH-entry circular buffer. Both sides use a
// valid/ready handshake.
//
// Hazard controls are applied with a fixed priority: flush > stall > normal.
// - flush discards every entry, rewinds both pointers and records how many
//   entries were thrown away. The output shows a bubble while flushing.
// - stall freezes the buffer. Both handshakes are forced low, so nothing
//   moves in either direction.
//
// Both handshakes are combinational. There is no bypass path, so a payload
// accepted at a clock edge is presented from that edge onward. This gives a
// fixed one-cycle latency and still allows one payload per cycle of
// throughput.
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int unsigned          WIDTH  = 64,
    parameter int unsigned          DEPTH  = 2,
    parameter logic [WIDTH-1:0]     BUBBLE = '0
) (
    input  logic                         clk,
    input  logic                         resetn,

    // Upstream side
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,

    // Downstream side
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,

    // Hazard controls
    input  logic                         stall,
    input  logic                         flush,

    // Status
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   flush_drops
);

    // -------------------------------------------------------------------------
    // Derived widths and constants
    // -------------------------------------------------------------------------
    localparam int unsigned CW = $clog2(DEPTH + 1);   // occupancy width
    localparam int unsigned PW = $clog2(DEPTH);       // pointer width

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    // -------------------------------------------------------------------------
    // Pointer advance helper.
    // DEPTH is a power of two, so the natural PW-bit wrap of the adder is
    // exactly the modulo-DEPTH wrap. No compare-and-clear logic is needed.
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        ptr_next = ptr + PTR_ONE;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [CW-1:0]    flush_drops_q, flush_drops_d;

    // -------------------------------------------------------------------------
    // Combinational handshake signals
    // -------------------------------------------------------------------------
    logic             hold_s;        // flush or stall: no handshake this cycle
    logic             not_full_s;
    logic             not_empty_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] out_data_s;

    // Handshake qualification: hazards mask both sides; occupancy gates each side.
    always_comb begin
        hold_s      = flush | stall;
        not_full_s  = (count_q != CNT_FULL);
        not_empty_s = (count_q != CNT_ZERO);

        // Full refuses input even if the head leaves this same cycle.
        // Accepting it would need a combinational out_ready -> in_ready path.
        in_ready_s  = (~hold_s) & not_full_s;
        out_valid_s = (~hold_s) & not_empty_s;

        push_s      = in_valid  & in_ready_s;
        pop_s       = out_valid & out_ready;
    end

    // Output payload mux: the head entry when presented, otherwise the bubble encoding.
    always_comb begin
        if (out_valid_s) begin
            out_data_s = mem_q[rd_ptr_q];
        end else begin
            out_data_s = BUBBLE;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic with fixed priority: flush > stall > normal.
    // -------------------------------------------------------------------------

    // Pointer, occupancy and drop-counter next-state under flush/stall/normal priority.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        flush_drops_d = flush_drops_q;

        if (flush) begin
            // Discard everything. The same-cycle input is not stored, because
            // in_ready is already low whenever flush is high.
            wr_ptr_d      = PTR_ZERO;
            rd_ptr_d      = PTR_ZERO;
            count_d       = CNT_ZERO;
            flush_drops_d = count_q;
        end else if (stall) begin
            // Freeze. push_s and pop_s are already forced low here, so the
            // hold values above stand.
            wr_ptr_d      = wr_ptr_q;
            rd_ptr_d      = rd_ptr_q;
            count_d       = count_q;
            flush_drops_d = flush_drops_q;
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;   // idle, or push and pop together
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------

    // Pointer and occupancy registers. Asynchronous reset empties the buffer at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Flush drop counter.
    // It is deliberately kept outside the reset domain, so that a reset in
    // the middle of operation still reports the last flush. Its value is
    // meaningful only after the first flush. Flushing an empty buffer once
    // after power-up sets it to zero.
    always_ff @(posedge clk) begin
        flush_drops_q <= flush_drops_d;
    end

    // Payload storage.
    // A write happens only on an accepted push. The contents are don't-care
    // after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign out_data    = out_data_s;
    assign count       = count_q;
    assign flush_drops = flush_drops_q;

endmodule
